xbus_gpio: RTL

XBUS_GPIO -- requirements
Module: xbus_gpio

---
 rtl/xbus_gpio_pkg.sv | 18 +
 rtl/gpio_debounce.sv | 71 +++++++
 rtl/xbus_gpio.sv | 122 ++++++++++++
 3 files changed

// File: rtl/xbus_gpio_pkg.sv
// Shared register map and byte-lane helper for the xbus_gpio block.
package xbus_gpio_pkg;

  localparam logic [2:0] REG_LED_DATA = 3'd0;
  localparam logic [2:0] REG_LED_SET  = 3'd1;
  localparam logic [2:0] REG_LED_CLR  = 3'd2;
  localparam logic [2:0] REG_SW_STATE = 3'd3;
  localparam logic [2:0] REG_SW_EDGE  = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;

  localparam logic [31:0] RESERVED_RD_VAL = 32'h0000_0000;

  // Expand the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One switch bit: 2-flop synchroniser plus optional stability counter.
// Counter logic only exists when XBUS_GPIO_DEBOUNCE_EN is defined.
module gpio_debounce #(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic change
);

  logic sync1_r;
  logic sync2_r;

  // Metastability synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
    end
  end

`ifdef XBUS_GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             stable_r;
  logic             accept_s;

  // Count consecutive disagreeing cycles; saturate into acceptance, never wrap.
  always_comb begin
    cnt_nxt_s = '0;
    accept_s  = 1'b0;
    if (sync2_r == stable_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      accept_s  = 1'b1;
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and accepted value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      stable_r <= accept_s ? sync2_r : stable_r;
    end
  end

  assign stable = stable_r;
  assign change = accept_s;
`else
  localparam int unsigned db_cycles_unused = DB_CYCLES;

  // The synchroniser output is the stable value; it changes on the next edge.
  assign stable = sync2_r;
  assign change = sync1_r ^ sync2_r;
`endif

endmodule

// File: rtl/xbus_gpio.sv
// XBUS-attached GPIO: LED register bank, debounced switches, edge flags, irq.
// Debouncing is enabled by defining XBUS_GPIO_DEBOUNCE_EN.
module xbus_gpio
  import xbus_gpio_pkg::*;
#(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xbus_cs,
  input  logic              xbus_we,
  input  logic [3:0]        xbus_be,
  input  logic [31:0]       xbus_addr,
  input  logic [31:0]       xbus_wdata,
  output logic [31:0]       xbus_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  logic [LED_W-1:0] led_r;
  logic [LED_W-1:0] led_nxt_s;
  logic [SW_W-1:0]  edge_r;
  logic [SW_W-1:0]  edge_nxt_s;
  logic [SW_W-1:0]  edge_clr_s;
  logic [SW_W-1:0]  irq_en_r;
  logic [SW_W-1:0]  irq_en_nxt_s;
  logic             irq_r;
  logic [SW_W-1:0]  stable_s;
  logic [SW_W-1:0]  change_s;

  logic        wr_s;
  logic [2:0]  idx_s;
  logic [31:0] mask_s;
  logic [31:0] wmask_s;
  logic [31:0] led32_s;
  logic        unused_addr_s;

  assign wr_s          = xbus_cs & xbus_we;
  assign idx_s         = xbus_addr[4:2];
  assign mask_s        = be_mask(xbus_be);
  assign wmask_s       = xbus_wdata & mask_s;
  assign led32_s       = 32'(led_r);
  assign unused_addr_s = ^{xbus_addr[31:5], xbus_addr[1:0]};

  for (genvar i = 0; i < SW_W; i++) begin : g_db
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw[i]),
      .stable(stable_s[i]),
      .change(change_s[i])
    );
  end

  // LED next state: direct write, set-on-one, clear-on-one.
  always_comb begin
    led_nxt_s = led_r;
    if (wr_s) begin
      case (idx_s)
        REG_LED_DATA: led_nxt_s = LED_W'((led32_s & ~mask_s) | wmask_s);
        REG_LED_SET:  led_nxt_s = LED_W'(led32_s | wmask_s);
        REG_LED_CLR:  led_nxt_s = LED_W'(led32_s & ~wmask_s);
        default:      led_nxt_s = led_r;
      endcase
    end else begin
      led_nxt_s = led_r;
    end
  end

  // Edge flags (a new change beats a coincident clear) and interrupt enables.
  always_comb begin
    edge_clr_s   = '0;
    irq_en_nxt_s = irq_en_r;
    if (wr_s && (idx_s == REG_SW_EDGE)) begin
      edge_clr_s = SW_W'(wmask_s);
    end else begin
      edge_clr_s = '0;
    end
    if (wr_s && (idx_s == REG_IRQ_EN)) begin
      irq_en_nxt_s = SW_W'((32'(irq_en_r) & ~mask_s) | wmask_s);
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
    edge_nxt_s = (edge_r & ~edge_clr_s) | change_s;
  end

  // Register state and the level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r    <= '0;
      edge_r   <= '0;
      irq_en_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      led_r    <= led_nxt_s;
      edge_r   <= edge_nxt_s;
      irq_en_r <= irq_en_nxt_s;
      irq_r    <= |(edge_r & irq_en_r);
    end
  end

  // Zero-wait read mux, independent of chip select.
  always_comb begin
    xbus_rdata = RESERVED_RD_VAL;
    case (idx_s)
      REG_LED_DATA, REG_LED_SET, REG_LED_CLR: xbus_rdata = led32_s;
      REG_SW_STATE: xbus_rdata = 32'(stable_s);
      REG_SW_EDGE:  xbus_rdata = 32'(edge_r);
      REG_IRQ_EN:   xbus_rdata = 32'(irq_en_r);
      default:      xbus_rdata = RESERVED_RD_VAL;
    endcase
  end

  assign led = led_r;
  assign irq = irq_r;

endmodule
